// File: rtl/imem_program_encoder.sv
// imem_program_encoder: accepts MIPS-style instruction requests one at a time,
// encodes each into a 32-bit word and writes it to sequential addresses of an
// instruction memory, starting at address 0 for each programming session.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; no requests accepted
// S_ACCEPT | in_ready high, waiting for a request handshake
// S_WRITE  | one-cycle memory write of the captured word
// S_DONE   | one-cycle done pulse, then back to idle
// S_ERROR  | illegal mnemonic seen; back to idle next cycle
module imem_program_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              error_q, error_d;
  logic [31:0]       enc_word;
  logic              enc_legal;

  // Combinational encoder; fields a format does not use are forced to zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_mnem)
      5'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      5'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      5'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      5'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      5'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
      5'd5:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000000};
      5'd6:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000010};
      5'd7:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000011};
      5'd8:  enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
      5'd9:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      5'd10: enc_word = {6'b001100, in_rs, in_rt, in_imm};
      5'd11: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      5'd12: enc_word = {6'b001110, in_rs, in_rt, in_imm};
      5'd13: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      5'd14: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      5'd15: enc_word = {6'b000100, in_rs, in_rt, in_imm};
      5'd16: enc_word = {6'b000101, in_rs, in_rt, in_imm};
      5'd17: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      5'd18: enc_word = {6'b000010, in_target};
      5'd19: enc_word = {6'b000011, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Next-state and output decode for the session FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    count_d  = count_q;
    full_d   = full_q;
    error_d  = error_q;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = '0;
          count_d = '0;
          full_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            addr_d  = ptr_q;
            last_d  = in_last;
            state_d = S_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        count_d = count_q + (ADDR_W+1)'(1);
        if (ptr_q == PTR_MAX) begin
          // Pointer saturates at the top address instead of wrapping.
          if (!last_q) full_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = last_q ? S_DONE : S_ACCEPT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A reset in the write cycle must suppress the pending memory write.
    if (rst) mem_we = 1'b0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      count_q <= count_d;
      full_q  <= full_d;
      error_q <= error_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign full      = full_q;
  assign error     = error_q;
  assign count     = count_q;

endmodule

// File: tb/tb_imem_program_encoder.sv
// Testbench for imem_program_encoder: directed scenarios plus randomized
// sessions, with memory writes checked by a scoreboard monitor.
module tb_imem_program_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk, rst, start, in_valid, in_ready, in_last;
  logic [4:0]    in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we, busy, done, full, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  imem_program_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .full(full), .error(error), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  exp_ptr, exp_count;
  bit  exp_full;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder built from the instruction format rules.
  function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt, input int rd,
                                          input int sh, input int imm, input int tgt);
    int rfunc[8] = '{32, 34, 36, 37, 38, 0, 2, 3};
    int iop[9]   = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
    longint w;
    w = 0;
    if (m <= 4)       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + rfunc[m];
    else if (m <= 7)  w = rt * 2**16 + rd * 2**11 + sh * 2**6 + rfunc[m];
    else if (m == 8)  w = rs * 2**21 + 8;
    else if (m <= 17) w = iop[m-9] * 2**26 + ((m == 17) ? 0 : rs * 2**21) + rt * 2**16 + imm;
    else              w = (m - 16) * 2**26 + tgt;
    return w[31:0];
  endfunction

  // Scoreboard monitor: every memory write must match the next expected entry.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 0);
    chk({tag, "_we"},    64'(mem_we), 0);
    chk({tag, "_addr"},  64'(mem_addr), 0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 0);
    chk({tag, "_busy"},  64'(busy), 0);
    chk({tag, "_done"},  64'(done), 0);
    chk({tag, "_full"},  64'(full), 0);
    chk({tag, "_error"}, 64'(error), 0);
    chk({tag, "_count"}, 64'(count), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_ptr   = 0;
    exp_count = 0;
    exp_full  = 1'b0;
    @(negedge clk);
    chk("start_ready",   64'(in_ready), 1);
    chk("start_busy",    64'(busy), 1);
    chk("start_err_clr", 64'(error), 0);
    chk("start_full_clr",64'(full), 0);
    chk("start_count",   64'(count), 0);
  endtask

  // Issue one request; legal words go into the scoreboard before the handshake.
  task automatic send(input int m, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last,
                      input bit use_ref, input logic [31:0] exp_word, output bit ended);
    int  waitc;
    wr_t e;
    waitc = 0;
    ended = 1'b0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 64'(in_ready), 1);
      ended = 1'b1;
      return;
    end
    in_mnem = 5'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last; in_valid = 1'b1;
    if (m < 20) begin
      e.addr = AW'(exp_ptr);
      e.data = use_ref ? ref_enc(m, rs, rt, rd, sh, imm, tgt) : exp_word;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_mnem = 5'($urandom);
    in_rs   = 5'($urandom);
    if (m >= 20) begin
      @(negedge clk);
      chk("err_no_we",      64'(mem_we), 0);
      chk("err_flag",       64'(error), 1);
      chk("err_ready",      64'(in_ready), 0);
      @(negedge clk);
      chk("err_idle_ready", 64'(in_ready), 0);
      chk("err_count",      64'(count), 64'(exp_count));
      chk("err_sticky",     64'(error), 1);
      ended = 1'b1;
      return;
    end
    @(negedge clk);
    chk("latency_we", 64'(mem_we), 1);
    exp_count++;
    if (exp_ptr == DEPTH - 1 || last) begin
      if (exp_ptr == DEPTH - 1 && !last) exp_full = 1'b1;
      @(negedge clk);
      chk("done_pulse", 64'(done), 1);
      chk("done_busy",  64'(busy), 0);
      chk("done_count", 64'(count), 64'(exp_count));
      chk("done_full",  64'(full), 64'(exp_full));
      @(negedge clk);
      chk("done_once",  64'(done), 0);
      chk("idle_ready", 64'(in_ready), 0);
      ended = 1'b1;
    end else begin
      exp_ptr++;
    end
  endtask

  initial begin
    bit  ended;
    wr_t e;
    int  n, m;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // add then sll with a nonzero rs that must be dropped
    do_start();
    send(0, 1, 2, 3, 0, 0, 0, 1'b0, 1'b0, 32'h00221820, ended);
    send(5, 7, 2, 5, 3, 0, 0, 1'b1, 1'b0, 32'h000228C0, ended);

    // addi, lw, j
    do_start();
    send(9, 0, 2, 0, 0, 5, 0, 1'b0, 1'b0, 32'h20020005, ended);
    send(13, 1, 4, 0, 0, 8, 0, 1'b0, 1'b0, 32'h8C240008, ended);
    send(18, 0, 0, 0, 0, 0, 32'h10, 1'b1, 1'b0, 32'h08000010, ended);

    // illegal mnemonic after one word; next start clears error
    do_start();
    send(3, 4, 5, 6, 0, 0, 0, 1'b0, 1'b1, 32'h0, ended);
    send(25, 1, 1, 1, 0, 0, 0, 1'b0, 1'b1, 32'h0, ended);
    do_start();
    send(1, 2, 3, 4, 0, 0, 0, 1'b1, 1'b1, 32'h0, ended);

    // fill the whole memory without last
    do_start();
    for (int i = 0; i < DEPTH; i++) send(11, i, i + 1, 0, 0, 16'h1234 + i, 0, 1'b0, 1'b1, 32'h0, ended);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_no_ready", 64'(in_ready), 0);
    end
    in_valid = 1'b0;
    chk("full_sticky", 64'(full), 1);

    // reset in the write cycle; rst also overrides start and in_valid
    do_start();
    @(negedge clk);
    in_mnem = 5'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_write_suppressed", 64'(mem_we), 0);
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");

    // in_valid held with start in idle; start during write ignored
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    in_mnem = 5'd0; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5; in_shamt = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("idle_valid_no_we", 64'(mem_we), 0);
    chk("idle_valid_ready", 64'(in_ready), 1);
    e.addr = '0;
    e.data = 32'h00642820;
    sb_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("write_we", 64'(mem_we), 1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("write_start_done", 64'(done), 1);
    @(negedge clk);
    chk("write_start_ignored_busy",  64'(busy), 0);
    chk("write_start_ignored_ready", 64'(in_ready), 0);

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      do_start();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        m = ($urandom_range(0, 15) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(m, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF),
             (i == n - 1), 1'b1, 32'h0, ended);
        if (ended) break;
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_program_encoder.md
IMEM_PROGRAM_ENCODER -- requirements
Module: imem_program_encoder

Interface
REQ-001 Parameter ADDR_W, default 6, meaning word-address width of target instruction memory (depth 2^ADDR_W).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  begin programming session; honoured only in IDLE.
REQ-005 in_valid  in  1  instruction request valid.
REQ-006 in_ready  out  1  block accepts request this cycle.
REQ-007 in_mnem  in  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 jr, 9 addi, 10 andi, 11 ori, 12 xori, 13 lw, 14 sw, 15 beq, 16 bne, 17 lui, 18 j, 19 jal; 20-31 illegal.
REQ-008 in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
REQ-009 in_imm  in  16  immediate/offset; in_target  in  26  jump target.
REQ-010 in_last  in  1  final instruction of session.
REQ-011 mem_we  out  1  instruction memory write strobe; mem_addr  out  ADDR_W; mem_wdata  out  32.
REQ-012 busy  out  1  session active; done  out  1  one-cycle end pulse; full  out  1  memory exhausted; error  out  1  illegal mnemonic seen; count  out  ADDR_W+1  words written this session.

Function
REQ-013 FSM states IDLE, ACCEPT, WRITE, DONE, ERROR.
REQ-014 IDLE: in_ready=0; start=1 -> clear count and address pointer to 0, clear error and full, go ACCEPT.
REQ-015 ACCEPT: in_ready=1, busy=1; handshake = in_valid&in_ready; on handshake register encoded word and in_last, go WRITE; illegal mnemonic -> go ERROR, nothing written.
REQ-016 WRITE: mem_we=1 for exactly one cycle, mem_addr=pointer, mem_wdata=registered word; pointer and count increment.
REQ-017 Latency: handshake in cycle N -> mem_we in cycle N+1; throughput one word per 2 cycles.
REQ-018 After WRITE: registered last=1 or pointer was 2^ADDR_W-1 -> DONE; else -> ACCEPT.
REQ-019 Writing address 2^ADDR_W-1 without last sets full=1 (sticky until next start/rst); pointer does not wrap, no further requests accepted.
REQ-020 DONE: done=1 one cycle, busy=0, -> IDLE.
REQ-021 ERROR: error=1 (sticky until start/rst), in_ready=0, -> IDLE next cycle; count holds words already written.
REQ-022 start asserted outside IDLE ignored; in_valid outside ACCEPT ignored.
REQ-023 R-type encoding: op=000000, {rs,rt,rd,shamt,func}; func add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011.
REQ-024 Shifts force rs=0; non-shift R-type force shamt=0; jr: rs only, rt=rd=shamt=0, func 001000.
REQ-025 I-type {op,rs,rt,imm}: addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111 (rs forced 0).
REQ-026 J-type {op,target}: j 000010, jal 000011.
REQ-027 Unused input fields ignored; encoding combinational from inputs, captured only on handshake.
REQ-028 mem_wdata, mem_addr hold value outside WRITE; mem_we=0 outside WRITE.

Reset
REQ-029 rst=1 at clock edge -> state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, full=0, error=0, count=0.
REQ-030 rst mid-session aborts immediately; pending registered word is not written; rst overrides start and in_valid in the same cycle.

Verification
REQ-031 start; add rs=1 rt=2 rd=3 (last=0); sll rt=2 rd=5 shamt=3 rs=7 (last=1) -> writes 0x00221820 @0, 0x000228C0 @1, done pulse, count=2.
REQ-032 addi rt=2 rs=0 imm=5; lw rt=4 rs=1 imm=8; j target=0x10 last -> 0x20020005 @0, 0x8C240008 @1, 0x08000010 @2.
REQ-033 in_mnem=25 after one valid word -> no write, error=1, count=1, returns IDLE; next start clears error.
REQ-034 ADDR_W=2, four words, none last -> writes @0..@3, full=1, done pulse, in_ready=0 afterwards.
REQ-035 rst asserted the cycle after a handshake -> no mem_we, all outputs at reset values next cycle.
REQ-036 in_valid held with start while IDLE -> first handshake only in ACCEPT, one cycle later; start during WRITE ignored.
